// File: rtl/deser_arbiter_if.sv
// deser_arbiter_if: bundles the serial front-end, deserializer and tagged-word signals of deser_arbiter.
//   slave  : arbiter side (inputs ch_data_i, ch_data_val_i, deser_data_i, deser_data_val_i;
//            outputs ch_ready_o, ser_data_o, ser_data_val_o, deser_srst_o, data_o, data_ch_o, data_val_o, timeout_o)
//   master : environment side (mirror of slave)
interface deser_arbiter_if #(
    parameter int NUM_CH         = 4,
    parameter int DATA_BUS_WIDTH = 16,
    parameter int CH_W           = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]         ch_data_i;
    logic [NUM_CH-1:0]         ch_data_val_i;
    logic [NUM_CH-1:0]         ch_ready_o;
    logic                      ser_data_o;
    logic                      ser_data_val_o;
    logic                      deser_srst_o;
    logic [DATA_BUS_WIDTH-1:0] deser_data_i;
    logic                      deser_data_val_i;
    logic [DATA_BUS_WIDTH-1:0] data_o;
    logic [CH_W-1:0]           data_ch_o;
    logic                      data_val_o;
    logic                      timeout_o;

    modport slave (
        input  ch_data_i, ch_data_val_i, deser_data_i, deser_data_val_i,
        output ch_ready_o, ser_data_o, ser_data_val_o, deser_srst_o,
               data_o, data_ch_o, data_val_o, timeout_o
    );

    modport master (
        output ch_data_i, ch_data_val_i, deser_data_i, deser_data_val_i,
        input  ch_ready_o, ser_data_o, ser_data_val_o, deser_srst_o,
               data_o, data_ch_o, data_val_o, timeout_o
    );
endinterface

// File: rtl/deser_arbiter.sv
// deser_arbiter: round-robin sharing of one serial-to-parallel deserializer among NUM_CH serial sources.
//   clk_i, srst_i : clock and synchronous active-high reset
//   bus (slave)   : per-channel serial bits with valid/ready, serial bit + valid + reset toward the
//                   deserializer, its parallel word back, and the channel-tagged word plus stall-flush pulse
module deser_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DATA_BUS_WIDTH = 16,
    parameter int TIMEOUT        = 64,
    parameter int CH_W           = $clog2(NUM_CH),
    parameter int COUNTER_SIZE   = $clog2(DATA_BUS_WIDTH + 1)
) (
    input logic           clk_i,
    input logic           srst_i,
    deser_arbiter_if.slave bus
);
    localparam int ST_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]           grant_q, grant_d;
    logic [COUNTER_SIZE-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ST_W-1:0]           stall_q, stall_d;
    logic [CH_W-1:0]           tag_q, tag_d;
    logic                      tag_valid_q, tag_valid_d;
    logic                      ser_data_q, ser_data_d;
    logic                      ser_val_q, ser_val_d;
    logic                      deser_srst_q, deser_srst_d;
    logic                      timeout_q, timeout_d;
    logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]           data_ch_q, data_ch_d;
    logic                      data_val_q, data_val_d;

    logic            found;
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] idx;
    int              sum;
    logic            beat;
    logic            last;
    logic            stall_out;
    logic            in_grant;
    logic            fire;

    // First valid channel at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        sum   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = int'(rr_ptr_q) + i;
            idx = CH_W'(sum >= NUM_CH ? sum - NUM_CH : sum);
            if (!found && bus.ch_data_val_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign in_grant  = state_q == GRANT;
    assign beat      = in_grant && bus.ch_data_val_i[grant_q];
    assign last      = beat && bit_cnt_q == COUNTER_SIZE'(DATA_BUS_WIDTH - 1);
    assign stall_out = in_grant && !beat && stall_q == ST_W'(TIMEOUT - 1);
    assign fire      = bus.deser_data_val_i && tag_valid_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE  ? (found ? GRANT : IDLE) :
                  state_q == GRANT ? (last ? IDLE : stall_out ? FLUSH : GRANT) :
                  IDLE;
    end

    always_comb begin
        bus.ch_ready_o = in_grant ? (NUM_CH'(1) << grant_q) : '0;
        grant_d        = (state_q == IDLE && found) ? pick : grant_q;
        rr_ptr_d       = (state_q == IDLE && found) ?
                         (int'(pick) == NUM_CH - 1 ? '0 : pick + 1'b1) : rr_ptr_q;
        bit_cnt_d      = beat ? bit_cnt_q + 1'b1 : in_grant ? bit_cnt_q : '0;
        stall_d        = in_grant ? (beat ? '0 : stall_q + 1'b1) : '0;
        ser_val_d      = beat;
        ser_data_d     = beat && bus.ch_data_i[grant_q];
        deser_srst_d   = stall_out;
        timeout_d      = stall_out;
        // A tag written in the same cycle a word returns must survive.
        tag_d          = last ? grant_q : tag_q;
        tag_valid_d    = last ? 1'b1 : fire ? 1'b0 : tag_valid_q;
        data_val_d     = fire;
        data_d         = fire ? bus.deser_data_i : '0;
        data_ch_d      = fire ? tag_q : '0;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            bit_cnt_q    <= '0;
            stall_q      <= '0;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            ser_data_q   <= 1'b0;
            ser_val_q    <= 1'b0;
            deser_srst_q <= 1'b1;
            timeout_q    <= 1'b0;
            data_q       <= '0;
            data_ch_q    <= '0;
            data_val_q   <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            bit_cnt_q    <= bit_cnt_d;
            stall_q      <= stall_d;
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            ser_data_q   <= ser_data_d;
            ser_val_q    <= ser_val_d;
            deser_srst_q <= deser_srst_d;
            timeout_q    <= timeout_d;
            data_q       <= data_d;
            data_ch_q    <= data_ch_d;
            data_val_q   <= data_val_d;
        end
    end

    assign bus.ser_data_o     = ser_data_q;
    assign bus.ser_data_val_o = ser_val_q;
    assign bus.deser_srst_o   = deser_srst_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.data_o         = data_q;
    assign bus.data_ch_o      = data_ch_q;
    assign bus.data_val_o     = data_val_q;
endmodule

// File: doc/deser_arbiter.md
Name: deser_arbiter

Overview:
Round-robin scheduler that shares one serial-to-parallel deserializer between NUM_CH serial sources.
- Grants one channel at a time for exactly one word of DATA_BUS_WIDTH bits and forwards that channel's bits to the deserializer.
- Tags each returned parallel word with the channel that produced it.
- Flushes the deserializer through its synchronous reset when a granted channel stalls.
- Sits between the per-channel serial front ends and the shared deserializer instance.

Parameters:
NUM_CH, 4, number of serial requesters (>=2)
DATA_BUS_WIDTH, 16, bits per word; must match the deserializer (>=2)
TIMEOUT, 64, stall cycles tolerated inside a grant before flush (>=2)
CH_W, $clog2(NUM_CH), channel index width
COUNTER_SIZE, $clog2(DATA_BUS_WIDTH+1), bit counter width

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous reset, active-high
ch_data_i  in  NUM_CH  serial bit per channel
ch_data_val_i  in  NUM_CH  bit valid per channel; source holds bit until ready
ch_ready_o  out  NUM_CH  bit accepted when ready&val (one-hot or zero)
ser_data_o  out  1  bit to deserializer data_i
ser_data_val_o  out  1  to deserializer data_val_i
deser_srst_o  out  1  to deserializer srst_i
deser_data_i  in  DATA_BUS_WIDTH  deserializer parallel output
deser_data_val_i  in  1  deserializer output valid
data_o  out  DATA_BUS_WIDTH  tagged word
data_ch_o  out  CH_W  source channel of data_o
data_val_o  out  1  word valid, one-cycle pulse
timeout_o  out  1  one-cycle pulse on stall flush

Behaviour:
- Clock and reset: one clock, clk_i. srst_i is synchronous and active-high. All outputs are registered except ch_ready_o.
- Reset values: ser_*=0, data_o=0, data_ch_o=0, data_val_o=0, timeout_o=0, deser_srst_o=1 (asserted for every cycle srst_i is sampled high), rr_ptr=0, state=IDLE, tag_valid=0.
- ch_ready_o is combinational: bit[grant]=1 only in state GRANT; otherwise all zero.
- IDLE:
  - Scan ch_data_val_i from rr_ptr upward, wrapping modulo NUM_CH. The first set channel becomes grant.
  - Next cycle: state=GRANT, rr_ptr=grant+1 (wrapping), bit counter=0, stall counter=0.
  - If no channel is valid, stay in IDLE.
- GRANT:
  - Each accepted beat registers ser_data_o=bit and ser_data_val_o=1 for the next cycle. Otherwise ser_data_val_o=0 and ser_data_o=0.
  - The bit counter increments per accepted beat. The stall counter clears on a beat and increments otherwise.
  - On the DATA_BUS_WIDTH-th beat: tag register <= grant, tag_valid <= 1, state <= IDLE.
  - If the stall counter reaches TIMEOUT-1 with no beat that cycle: state <= FLUSH.
- FLUSH (one cycle):
  - deser_srst_o=1 and timeout_o=1 are registered high for exactly one cycle.
  - tag_valid is untouched; no word is tagged for the aborted grant.
  - Then state <= IDLE. rr_ptr already points past the stalled channel.
- Return path:
  - On deser_data_val_i with tag_valid=1: next cycle data_o=deser_data_i, data_ch_o=tag, data_val_o=1; tag_valid <= 0.
  - If a new tag is written in the same cycle, the write wins (tag_valid stays 1).
  - On deser_data_val_i with tag_valid=0: the word is dropped and data_val_o stays 0.
  - When data_val_o=0, data_o and data_ch_o are driven to 0.
- Latency: the deserializer has 2-cycle latency. data_val_o rises 4 cycles after the clock edge that accepts the last bit (edge t: ser valid t+1, deser sample, deser valid t+3, data_val_o t+4).
- Minimum inter-word gap is 1 IDLE cycle, so a single tag register never overflows for DATA_BUS_WIDTH>=2.
- Reset mid-word: the partial word is discarded and nothing is tagged. Arbitration restarts from channel 0 after reset releases.

Test Plan:
1. NUM_CH=4, W=16: ch2 alone streams 0xA5C3 MSB first, valid continuous -> ch_ready_o=4'b0100 for 16 cycles; data_o=0xA5C3, data_ch_o=2, data_val_o pulses once 4 cycles after the last acceptance.
2. ch0, ch1, ch3 all valid continuously with words 0x1111, 0x2222, 0x3333 -> outputs in order ch0, ch1, ch3, ch0, with one IDLE cycle between grants.
3. TIMEOUT=8: ch1 sends 5 bits, then drops valid -> timeout_o and deser_srst_o pulse 1 cycle, no data_val_o, next grant goes to ch2 if valid. ch1 later resends 0xBEEF in full -> 0xBEEF tagged ch1.
4. ch3 sends 0x8001 with valid gaps of 1-6 cycles (all below TIMEOUT) -> no flush; data_o=0x8001, data_ch_o=3.
5. srst_i asserted after 9 bits of 0xFFFF on ch0 -> ready=0, all outputs at reset values, deser_srst_o=1 during reset. Post-reset 0x00F0 on ch0 -> correct word, ch 0.
6. deser_data_val_i forced high with tag_valid=0 -> data_val_o stays 0; a following legitimate word is still tagged correctly.
